st2bus_turbo: RTL and testbench
===============================

Name: st2bus_turbo

Overview:
- Packs the decoded Avalon-ST output of the turbo decoder array (ST-bit beats with sop/eop/valid/ready) back into BUS-wide words for the host bus.
- This is the return path, the reverse of the bus-to-stream adaptor that feeds the decoders.
- Sits after the turbo output mux. Each decoded 1024-bit block becomes 2 bus words, each carrying a 22-bit header.
- Single clock domain.

Parameters:
BUS, 534, output bus word width
ST, 8, stream beat width
PAYLOAD, 512, payload bits per bus word (bits [PAYLOAD-1:0])
BEATS_PER_PKT, 128, beats in a well-formed packet (1024/ST)
SEQ_W, 16, packet sequence number width
Derived constants: BEATS_PER_WORD = PAYLOAD/ST = 64; WORDS_PER_PKT = 2.

Ports:
clk_bus  in  1  bus clock
rst_n  in  1  asynchronous reset, active low
st_data  in  ST  decoded beat
st_valid  in  1  beat valid
st_sop  in  1  first beat of packet
st_eop  in  1  last beat of packet
st_ready  out  1  block can accept a beat this cycle
bus_data  out  BUS  packed word
bus_en  out  1  bus_data valid
bus_ready  in  1  downstream accepts the word

Behaviour:
- Reset is asynchronous and active low.
  - While in reset: bus_en=0, bus_data=0, st_ready=0.
  - Also cleared in reset: FSM=IDLE, beat counter=0, sequence number=0.
  - After reset releases, st_ready=1.
- Handshakes:
  - A beat transfers when st_valid && st_ready.
  - A word transfers when bus_en && bus_ready.
  - bus_en and bus_data are registered and held stable until accepted. bus_en never drops without a transfer.
- Packing:
  - Beat k of a word (k = beat index mod 64) is placed at bus_data[k*ST +: ST], so the first beat lands at the LSBs.
  - Unfilled beats of a flushed word are zero.
- Header fields:
  - [533] first word of packet.
  - [532] last word of packet.
  - [531] error.
  - [530:515] sequence number.
  - [514:512] word index within packet (0..1).
- Storage: one assembly register plus one output register.
  - A completed assembly word moves to the output register when it is empty or is being accepted in the same cycle.
  - st_ready = 0 only while a completed assembly word is waiting for the output register.
  - Latency: a word appears on bus_en the cycle after its final beat is accepted, provided the output register is free.
- FSM states: IDLE, FILL, DROP.
  - IDLE: a beat without sop is discarded (st_ready=1). A beat with sop is stored as beat 0 and the FSM goes to FILL; if eop is also set, see the eop-in-FILL rule.
  - FILL, beat with eop at count 127: the packet is good. Close the word (last=1, error=0) and go to IDLE.
  - FILL, beat with eop at count < 127: a short packet. Close the current word (last=1, error=1, zero-padded). Remaining words of the packet are not emitted. Go to IDLE.
  - FILL, beat at count 127 without eop: a long packet. Close the word (last=1, error=1) and go to DROP.
  - FILL, beat with sop (count > 0): the previous packet was truncated.
    - First, the partial word is closed (last=1, error=1, zero-padded).
    - Then the new packet starts with this beat as beat 0, with sequence number +1.
    - This needs the output register free. If it is not, st_ready=0 that cycle and the beat is held by the upstream.
  - DROP: beats are discarded with st_ready=1. A beat with eop returns the FSM to IDLE. A beat with sop is treated as in IDLE.
- Sequence number increments by 1 on each packet close and wraps modulo 2^SEQ_W.
- Word index: 0 for beats 0..63, 1 for beats 64..127. first=1 only on word index 0.
- Reset mid-operation discards all partial and held data. There is no residual bus_en after reset.

Decomposition:
- Shared package turbo_pkg holds:
  - the constants BUS, ST, PAYLOAD, BEATS_PER_PKT, SEQ_W;
  - the header bit positions (HDR_FIRST=533, HDR_LAST=532, HDR_ERR=531, HDR_SEQ_LSB=515, HDR_IDX_LSB=512);
  - the FSM state encoding.
- One natural sub-module: st2bus_out_reg, the single-entry output holding register with the valid/ready handshake.
- Packing and the FSM stay in the top module.

Test Plan:
- Good packet: 128 beats with data = beat index, sop on 0, eop on 127, bus_ready=1.
  - Expect 2 words.
  - word0: bytes 0..63, header first=1 last=0 err=0 seq=0 idx=0.
  - word1: bytes 64..127 (0x40..0x7F), first=0 last=1 seq=0 idx=1.
- Backpressure: bus_ready=0 for 200 cycles during two back-to-back packets.
  - st_ready falls once word0 is held and word1 has assembled.
  - When released, 4 words arrive in order with seq 0,0,1,1 and no lost or duplicated bytes.
- Short packet: sop at beat 0, eop at beat 9, data 0xA5.
  - Expect 1 word with bytes 0..9 = 0xA5 and bytes 10..63 = 0.
  - Header first=1 last=1 err=1.
  - The next packet has seq+1.
- Long packet: 130 beats, eop on beat 129.
  - The word with idx=1 has last=1 err=1.
  - Beats 128 and 129 are dropped with st_ready=1.
  - No third word is emitted.
- Sop mid-packet: new sop at beat 40.
  - The partial word is emitted with last=1 err=1 and bytes 40..63 = 0.
  - The new packet's word0 starts with the beat-40 data and has seq+1.
- Reset mid-packet: assert rst_n=0 after 70 beats.
  - bus_en=0 immediately and st_ready=0.
  - After release, the next good packet reports seq=0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared constants, header layout and FSM encoding for the turbo return path.
// Holds bus/stream widths, derived counter widths, header bit positions,
// the header struct and a helper that glues a header onto a payload.
package turbo_pkg;

  localparam int BUS           = 534;
  localparam int ST            = 8;
  localparam int PAYLOAD       = 512;
  localparam int BEATS_PER_PKT = 128;
  localparam int SEQ_W         = 16;

  localparam int BEATS_PER_WORD = PAYLOAD / ST;                     // 64
  localparam int WORDS_PER_PKT  = BEATS_PER_PKT / BEATS_PER_WORD;   // 2

  localparam int HDR_FIRST   = 533;
  localparam int HDR_LAST    = 532;
  localparam int HDR_ERR     = 531;
  localparam int HDR_SEQ_LSB = 515;
  localparam int HDR_IDX_LSB = 512;

  localparam int IDX_W = HDR_SEQ_LSB - HDR_IDX_LSB;     // word index field width
  localparam int CNT_W = $clog2(BEATS_PER_PKT);         // beat counter within packet
  localparam int WB_W  = $clog2(BEATS_PER_WORD);        // beat position within word
  localparam int PB_W  = $clog2(PAYLOAD);               // bit position within payload

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Field order mirrors bits [BUS-1:PAYLOAD] of a bus word, MSB first.
  typedef struct packed {
    logic             first;
    logic             last;
    logic             err;
    logic [SEQ_W-1:0] seq;
    logic [IDX_W-1:0] idx;
  } hdr_t;

  function automatic logic [BUS-1:0] mk_word(input hdr_t h, input logic [PAYLOAD-1:0] p);
    return {h, p};
  endfunction

endpackage

// File: rtl/st2bus_turbo_if.sv
// Stream-in / bus-out signal bundle for st2bus_turbo.
// master: the packer side (consumes beats, produces bus words).
// slave:  the environment side (produces beats, consumes bus words).
interface st2bus_turbo_if;
  import turbo_pkg::*;

  logic [ST-1:0]  st_data;
  logic           st_valid;
  logic           st_sop;
  logic           st_eop;
  logic           st_ready;
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic           bus_ready;

  modport master (
    input  st_data, st_valid, st_sop, st_eop, bus_ready,
    output st_ready, bus_data, bus_en
  );

  modport slave (
    output st_data, st_valid, st_sop, st_eop, bus_ready,
    input  st_ready, bus_data, bus_en
  );

endinterface

// File: rtl/st2bus_out_reg.sv
// Single-entry registered output stage with valid/ready handshake.
// Latency: i_load shows on o_vld/o_dat the next cycle; data held until i_rdy.
// Backpressure: o_free tells the producer it may load (empty or draining now).
// Ports: clk/rst_n; i_load/i_dat load a word; i_rdy downstream accept;
//        o_vld/o_dat registered word; o_free load permitted this cycle.
module st2bus_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_dat,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic         o_free
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_dat  = r_dat;
  assign o_free = !r_vld || i_rdy;

endmodule

// File: rtl/st2bus_turbo.sv
// Packs decoded ST-bit stream beats into BUS-wide headered words for the host.
// Latency: a word is on bus_en the cycle after its last beat if the output reg is free.
// Backpressure: st_ready drops while a finished word waits in the assembly reg,
// or when a truncating sop needs the output reg and it is busy.
// Ports: clk_bus/rst_n; bus_if (master) carries st_* beats in and bus_* words out.
module st2bus_turbo
  import turbo_pkg::*;
(
  input  logic           clk_bus,
  input  logic           rst_n,
  st2bus_turbo_if.master bus_if
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SEQ_W-1:0]   r_seq, w_seq_nxt;
  logic [PAYLOAD-1:0] r_asm_dat, w_asm_dat_nxt;
  hdr_t               r_asm_hdr, w_asm_hdr_nxt;
  logic               r_asm_full, w_asm_full_nxt;
  logic               r_run;

  logic               w_st_ready, w_acc, w_trunc, w_keep, w_close;
  logic               w_last_beat, w_word_end;
  logic [CNT_W-1:0]   w_idx;
  logic [PB_W-1:0]    w_bitpos;
  logic [SEQ_W-1:0]   w_pkt_seq;
  logic [PAYLOAD-1:0] w_merged;
  hdr_t               w_hdr_new, w_hdr_trunc;
  logic               w_out_load, w_out_free, w_bus_en;
  logic [BUS-1:0]     w_out_dat, w_bus_data;

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_asm_dat  <= '0;
      r_asm_hdr  <= '0;
      r_asm_full <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seq      <= w_seq_nxt;
      r_asm_dat  <= w_asm_dat_nxt;
      r_asm_hdr  <= w_asm_hdr_nxt;
      r_asm_full <= w_asm_full_nxt;
      r_run      <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_seq_nxt      = r_seq;
    w_asm_dat_nxt  = r_asm_dat;
    w_asm_hdr_nxt  = r_asm_hdr;
    w_asm_full_nxt = r_asm_full;
    w_out_load     = 1'b0;
    w_out_dat      = mk_word(r_asm_hdr, r_asm_dat);

    // A sop arriving mid-packet flushes the partial word straight to the
    // output register, so it may only be taken when that register is free.
    w_st_ready = r_run && !r_asm_full &&
                 !((r_state == S_FILL) && bus_if.st_valid && bus_if.st_sop && !w_out_free);
    w_acc      = bus_if.st_valid && w_st_ready;

    w_trunc     = (r_state == S_FILL) && bus_if.st_sop;
    w_keep      = bus_if.st_sop || (r_state == S_FILL);
    w_idx       = bus_if.st_sop ? '0 : r_cnt;
    w_pkt_seq   = w_trunc ? r_seq + SEQ_W'(1) : r_seq;
    w_last_beat = (w_idx == CNT_W'(BEATS_PER_PKT - 1));
    w_word_end  = (w_idx[WB_W-1:0] == '1);
    w_close     = w_keep && (bus_if.st_eop || w_word_end);

    w_bitpos = PB_W'(w_idx[WB_W-1:0]) * PB_W'(ST);
    w_merged = bus_if.st_sop ? '0 : r_asm_dat;
    w_merged[w_bitpos +: ST] = bus_if.st_data;

    // eop exactly on the final beat is the only clean close; eop early or
    // no eop on the final beat both mark the word as errored.
    w_hdr_new.first = !w_idx[CNT_W-1];
    w_hdr_new.last  = bus_if.st_eop || w_last_beat;
    w_hdr_new.err   = bus_if.st_eop ^ w_last_beat;
    w_hdr_new.seq   = w_pkt_seq;
    w_hdr_new.idx   = IDX_W'(w_idx[CNT_W-1]);

    w_hdr_trunc.first = !r_cnt[CNT_W-1];
    w_hdr_trunc.last  = 1'b1;
    w_hdr_trunc.err   = 1'b1;
    w_hdr_trunc.seq   = r_seq;
    w_hdr_trunc.idx   = IDX_W'(r_cnt[CNT_W-1]);

    if (r_asm_full) begin
      if (w_out_free) begin
        w_out_load     = 1'b1;
        w_out_dat      = mk_word(r_asm_hdr, r_asm_dat);
        w_asm_full_nxt = 1'b0;
        w_asm_dat_nxt  = '0;
      end
    end else if (w_acc) begin
      if (w_trunc) begin
        w_out_load = 1'b1;
        w_out_dat  = mk_word(w_hdr_trunc, r_asm_dat);
        w_seq_nxt  = w_pkt_seq;
      end
      if (w_keep) begin
        w_state_nxt   = S_FILL;
        w_cnt_nxt     = w_idx + CNT_W'(1);
        w_asm_dat_nxt = w_merged;
        if (w_close) begin
          // Bypass the assembly register when the output stage can take the
          // word now; otherwise park it there and stall the stream.
          if (!w_out_load && w_out_free) begin
            w_out_load    = 1'b1;
            w_out_dat     = mk_word(w_hdr_new, w_merged);
            w_asm_dat_nxt = '0;
          end else begin
            w_asm_full_nxt = 1'b1;
            w_asm_hdr_nxt  = w_hdr_new;
          end
          if (w_hdr_new.last) begin
            w_seq_nxt   = w_pkt_seq + SEQ_W'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = bus_if.st_eop ? S_IDLE : S_DROP;
          end
        end
      end else if ((r_state == S_DROP) && bus_if.st_eop) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  st2bus_out_reg #(.W(BUS)) u_out_reg (
    .clk    (clk_bus),
    .rst_n  (rst_n),
    .i_load (w_out_load),
    .i_dat  (w_out_dat),
    .i_rdy  (bus_if.bus_ready),
    .o_vld  (w_bus_en),
    .o_dat  (w_bus_data),
    .o_free (w_out_free)
  );

  assign bus_if.st_ready = w_st_ready;
  assign bus_if.bus_en   = w_bus_en;
  assign bus_if.bus_data = w_bus_data;

endmodule

// File: tb/tb_st2bus_turbo.sv
// Directed bench for st2bus_turbo: packet-level vector table plus hand-written
// backpressure, mid-packet sop and mid-packet reset sequences.
module tb_st2bus_turbo;
  import turbo_pkg::*;

  logic clk_bus = 1'b0;
  logic rst_n;
  st2bus_turbo_if tbi();

  st2bus_turbo dut (
    .clk_bus (clk_bus),
    .rst_n   (rst_n),
    .bus_if  (tbi.master)
  );

  always #5 clk_bus = ~clk_bus;

  int checks   = 0;
  int failures = 0;
  logic [BUS-1:0] q[$];
  logic [BUS-1:0] eq[$];

  typedef struct {
    int         nbeats;
    int         eop_at;
    logic [7:0] base;
    logic [7:0] step;
    int         nwords;
    hdr_t       h0;
    hdr_t       h1;
    int         stored;
    bit         lat;
  } vec_t;
  vec_t vecs[6];

  always @(negedge clk_bus)
    if (rst_n && tbi.bus_en && tbi.bus_ready) q.push_back(tbi.bus_data);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic hdr_t mkh(input bit f, input bit l, input bit e, input int s, input int idx);
    hdr_t h;
    h.first = f;
    h.last  = l;
    h.err   = e;
    h.seq   = SEQ_W'(s);
    h.idx   = IDX_W'(idx);
    return h;
  endfunction

  // Beat n of a packet carries base + step*n; beats at or past 'stored' are zero.
  function automatic logic [BUS-1:0] exp_word(input hdr_t h, input logic [7:0] base,
                                              input logic [7:0] step, input int widx,
                                              input int stored);
    logic [PAYLOAD-1:0] p;
    p = '0;
    for (int b = 0; b < BEATS_PER_WORD; b++) begin
      int beat;
      beat = widx * BEATS_PER_WORD + b;
      if (beat < stored) p[b*ST +: ST] = 8'(int'(base) + int'(step) * beat);
    end
    return {h, p};
  endfunction

  task automatic send_beat(input logic [7:0] d, input bit s, input bit e, output bit rdy_now);
    int n;
    n = 0;
    tbi.st_data  = d;
    tbi.st_sop   = s;
    tbi.st_eop   = e;
    tbi.st_valid = 1'b1;
    @(negedge clk_bus);
    rdy_now = tbi.st_ready;
    while (!tbi.st_ready && n < 1000) begin
      @(negedge clk_bus);
      n++;
    end
    if (!tbi.st_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: st_ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk_bus);
    #1;
    tbi.st_valid = 1'b0;
    tbi.st_sop   = 1'b0;
    tbi.st_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input int eop_at, input logic [7:0] base, input logic [7:0] step);
    bit r;
    for (int i = 0; i < nb; i++) begin
      send_beat(8'(int'(base) + int'(step) * i), i == 0, i == eop_at, r);
      if (i >= BEATS_PER_PKT) chkv($sformatf("drop_rdy_b%0d", i), int'(r), 1);
    end
  endtask

  task automatic drain_cmp(input string nm);
    int t;
    t = 0;
    while (q.size() < eq.size() && t < 500) begin
      @(negedge clk_bus);
      t++;
    end
    repeat (8) @(negedge clk_bus);
    chkv({nm, "_nwords"}, q.size(), eq.size());
    for (int i = 0; i < eq.size() && i < q.size(); i++) begin
      chk($sformatf("%s_w%0d_hdr", nm, i), BUS'(q[i][BUS-1:PAYLOAD]), BUS'(eq[i][BUS-1:PAYLOAD]));
      chk($sformatf("%s_w%0d_payload", nm, i), BUS'(q[i][PAYLOAD-1:0]), BUS'(eq[i][PAYLOAD-1:0]));
    end
    q.delete();
    eq.delete();
  endtask

  initial begin
    tbi.st_data   = '0;
    tbi.st_valid  = 1'b0;
    tbi.st_sop    = 1'b0;
    tbi.st_eop    = 1'b0;
    tbi.bus_ready = 1'b1;
    rst_n         = 1'b0;

    // nbeats eop base step nwords hdr0 hdr1 stored latency-check
    vecs[0] = '{128, 127, 8'h00, 8'h01, 2, mkh(1,0,0,0,0), mkh(0,1,0,0,1), 128, 1'b1}; // good
    vecs[1] = '{ 10,   9, 8'hA5, 8'h00, 1, mkh(1,1,1,1,0), mkh(0,0,0,0,0),  10, 1'b1}; // short
    vecs[2] = '{128, 127, 8'h33, 8'h01, 2, mkh(1,0,0,2,0), mkh(0,1,0,2,1), 128, 1'b1}; // good
    vecs[3] = '{130, 129, 8'h00, 8'h01, 2, mkh(1,0,0,3,0), mkh(0,1,1,3,1), 128, 1'b0}; // long
    vecs[4] = '{128, 127, 8'hF0, 8'h03, 2, mkh(1,0,0,4,0), mkh(0,1,0,4,1), 128, 1'b1}; // good
    vecs[5] = '{  1,   0, 8'h3C, 8'h00, 1, mkh(1,1,1,5,0), mkh(0,0,0,0,0),   1, 1'b1}; // sop+eop

    repeat (3) @(negedge clk_bus);
    chkv("rst_bus_en", int'(tbi.bus_en), 0);
    chk("rst_bus_data", tbi.bus_data, '0);
    chkv("rst_st_ready", int'(tbi.st_ready), 0);
    @(posedge clk_bus);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk_bus);
    chkv("post_rst_st_ready", int'(tbi.st_ready), 1);
    @(posedge clk_bus);
    #1;

    for (int v = 0; v < 6; v++) begin
      send_pkt(vecs[v].nbeats, vecs[v].eop_at, vecs[v].base, vecs[v].step);
      if (vecs[v].lat) chkv($sformatf("v%0d_latency_bus_en", v), int'(tbi.bus_en), 1);
      eq.push_back(exp_word(vecs[v].h0, vecs[v].base, vecs[v].step, 0, vecs[v].stored));
      if (vecs[v].nwords > 1)
        eq.push_back(exp_word(vecs[v].h1, vecs[v].base, vecs[v].step, 1, vecs[v].stored));
      drain_cmp($sformatf("v%0d", v));
      @(posedge clk_bus);
      #1;
    end

    // Two back-to-back packets against a stalled bus.
    tbi.bus_ready = 1'b0;
    fork
      begin
        send_pkt(128, 127, 8'h00, 8'h01);
        send_pkt(128, 127, 8'h55, 8'h01);
      end
      begin
        repeat (200) @(posedge clk_bus);
        @(negedge clk_bus);
        chkv("bp_st_ready_low", int'(tbi.st_ready), 0);
        chkv("bp_bus_en_held", int'(tbi.bus_en), 1);
        chkv("bp_no_early_words", q.size(), 0);
        @(posedge clk_bus);
        #1 tbi.bus_ready = 1'b1;
      end
    join
    eq.push_back(exp_word(mkh(1,0,0,6,0), 8'h00, 8'h01, 0, 128));
    eq.push_back(exp_word(mkh(0,1,0,6,1), 8'h00, 8'h01, 1, 128));
    eq.push_back(exp_word(mkh(1,0,0,7,0), 8'h55, 8'h01, 0, 128));
    eq.push_back(exp_word(mkh(0,1,0,7,1), 8'h55, 8'h01, 1, 128));
    drain_cmp("bp");
    @(posedge clk_bus);
    #1;

    // New sop arrives where beat 40 would have been.
    send_pkt(40, -1, 8'h10, 8'h01);
    send_pkt(128, 127, 8'h80, 8'h01);
    eq.push_back(exp_word(mkh(1,1,1,8,0), 8'h10, 8'h01, 0, 40));
    eq.push_back(exp_word(mkh(1,0,0,9,0), 8'h80, 8'h01, 0, 128));
    eq.push_back(exp_word(mkh(0,1,0,9,1), 8'h80, 8'h01, 1, 128));
    drain_cmp("sopmid");
    @(posedge clk_bus);
    #1;

    // Reset after 70 beats; word0 of that packet has already gone out.
    send_pkt(70, -1, 8'h00, 8'h01);
    rst_n = 1'b0;
    #1;
    chkv("midrst_bus_en", int'(tbi.bus_en), 0);
    chkv("midrst_st_ready", int'(tbi.st_ready), 0);
    chk("midrst_bus_data", tbi.bus_data, '0);
    q.delete();
    repeat (3) @(posedge clk_bus);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk_bus);
    chkv("midrst_no_residual_bus_en", int'(tbi.bus_en), 0);
    @(posedge clk_bus);
    #1;
    send_pkt(128, 127, 8'h22, 8'h01);
    eq.push_back(exp_word(mkh(1,0,0,0,0), 8'h22, 8'h01, 0, 128));
    eq.push_back(exp_word(mkh(0,1,0,0,1), 8'h22, 8'h01, 1, 128));
    drain_cmp("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
